// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file writeback path.
// Contents: default address/data widths, the x0 register index, and the
// address/data typedefs used by blocks that talk to the register file.
package regfile_ctrl_pkg;

  localparam int unsigned DEF_AW = 5;
  localparam int unsigned DEF_DW = 32;

  // Architectural zero register; writes to it are dropped.
  localparam logic [DEF_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req  in  N   request vector
//   ptr  in  PW  highest-priority index this cycle (must be < N)
//   en   in  1   grant enable; gnt is all-zero while low
//   gnt  out N   one-hot grant (all-zero when no request or disabled)
// Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    if (en) begin
      // Upper segment [ptr, N-1] has priority over the wrapped segment [0, ptr-1].
      for (int i = 0; i < int'(N); i++) begin
        if (!w_found && req[i] && (i >= int'(ptr))) begin
          gnt[i]  = 1'b1;
          w_found = 1'b1;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (!w_found && req[i] && (i < int'(ptr))) begin
          gnt[i]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write port among
// NREQ writeback requesters with round-robin grant and valid/ready handshakes.
// The winning write appears on WE3/A3/WD3 exactly one cycle after the handshake.
// Writes to x0 are accepted but never enable the port and are not counted.
// Ports:
//   CLK         in   clock
//   rst         in   synchronous active-high reset
//   wb_stall    in   pipeline freeze; blocks new grants only
//   req_valid   in   NREQ     per-requester write pending
//   req_addr    in   NREQ*AW  per-requester destination, [i*AW +: AW]
//   req_data    in   NREQ*DW  per-requester data, [i*DW +: DW]
//   req_ready   out  NREQ     one-hot grant (combinational)
//   WE3/A3/WD3  out           registered regfile write port
//   commit_cnt  out  CW       wrapping count of non-x0 writes issued
// Optional feature (macro REGFILE_WB_FWD_EN): adds rd_a1/rd_a2, rf_rd1/rf_rd2
// and fwd_rd1/fwd_rd2, a combinational bypass of the in-flight write onto
// the two read ports.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned CW   = 16
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               wb_stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
`ifdef REGFILE_WB_FWD_EN
  input  logic [AW-1:0]      rd_a1,
  input  logic [AW-1:0]      rd_a2,
  input  logic [DW-1:0]      rf_rd1,
  input  logic [DW-1:0]      rf_rd2,
  output logic [DW-1:0]      fwd_rd1,
  output logic [DW-1:0]      fwd_rd2,
`endif
  output logic               WE3,
  output logic [AW-1:0]      A3,
  output logic [DW-1:0]      WD3,
  output logic [CW-1:0]      commit_cnt
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  logic [PW-1:0]   r_rr_ptr;
  logic            r_we3;
  logic [AW-1:0]   r_a3;
  logic [DW-1:0]   r_wd3;
  logic [CW-1:0]   r_commit_cnt;

  logic [NREQ-1:0] w_gnt;
  logic            w_accept;
  logic [PW-1:0]   w_gnt_idx;
  logic [AW-1:0]   w_gnt_addr;
  logic [DW-1:0]   w_gnt_data;
  logic            w_gnt_nz;
  logic [PW-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .en  (!rst && !wb_stall),
    .gnt (w_gnt)
  );

  // Grant is a subset of valid, so any grant bit is a completed handshake.
  assign w_accept  = |w_gnt;
  assign req_ready = w_gnt;

  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = PW'(i);
        w_gnt_addr = req_addr[i*AW +: AW];
        w_gnt_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_gnt_nz  = (w_gnt_addr != ZeroAddr);
  assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_we3        <= 1'b0;
      r_a3         <= '0;
      r_wd3        <= '0;
      r_commit_cnt <= '0;
      r_rr_ptr     <= '0;
    end else if (w_accept) begin
      r_we3    <= w_gnt_nz;
      r_a3     <= w_gnt_addr;
      r_wd3    <= w_gnt_data;
      r_rr_ptr <= w_ptr_nxt;
      if (w_gnt_nz) begin
        r_commit_cnt <= r_commit_cnt + CW'(1);
      end
    end else begin
      // Address/data hold so the port stays quiet between writes.
      r_we3 <= 1'b0;
    end
  end

  assign WE3        = r_we3;
  assign A3         = r_a3;
  assign WD3        = r_wd3;
  assign commit_cnt = r_commit_cnt;

`ifdef REGFILE_WB_FWD_EN
  logic w_hit1;
  logic w_hit2;

  assign w_hit1  = r_we3 && (r_a3 == rd_a1) && (r_a3 != ZeroAddr);
  assign w_hit2  = r_we3 && (r_a3 == rd_a2) && (r_a3 != ZeroAddr);
  assign fwd_rd1 = w_hit1 ? r_wd3 : rf_rd1;
  assign fwd_rd2 = w_hit2 ? r_wd3 : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32, CW=4).
// A narrow commit counter lets the wrap from 15 to 0 be exercised quickly.
module tb_regfile_wb_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;

  logic               CLK = 1'b0;
  logic               rst;
  logic               wb_stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               WE3;
  logic [AW-1:0]      A3;
  logic [DW-1:0]      WD3;
  logic [CW-1:0]      commit_cnt;
`ifdef REGFILE_WB_FWD_EN
  logic [AW-1:0]      rd_a1;
  logic [AW-1:0]      rd_a2;
  logic [DW-1:0]      rf_rd1;
  logic [DW-1:0]      rf_rd2;
  logic [DW-1:0]      fwd_rd1;
  logic [DW-1:0]      fwd_rd2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW),
    .CW   (CW)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .wb_stall   (wb_stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
`ifdef REGFILE_WB_FWD_EN
    .rd_a1      (rd_a1),
    .rd_a2      (rd_a2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .fwd_rd1    (fwd_rd1),
    .fwd_rd2    (fwd_rd2),
`endif
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .commit_cnt (commit_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst       = 1'b1;
    wb_stall  = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
`ifdef REGFILE_WB_FWD_EN
    rd_a1  = '0;
    rd_a2  = '0;
    rf_rd1 = '0;
    rf_rd2 = '0;
`endif
    set_req(0, 5'd1, 32'h1000_0000);
    set_req(1, 5'd2, 32'h1000_0001);
    set_req(2, 5'd3, 32'h1000_0002);

    // Reset held two cycles with every requester valid.
    #1;
    check_eq("rst_ready_c0", req_ready, 3'b000);
    tick();
    check_eq("rst_ready_c1", req_ready, 3'b000);
    tick();
    check_eq("rst_we3", WE3, 1'b0);
    check_eq("rst_a3", A3, 5'd0);
    check_eq("rst_wd3", WD3, 32'd0);
    check_eq("rst_cnt", commit_cnt, 4'd0);
    rst = 1'b0;
    #1;
    check_eq("first_grant_req0", req_ready, 3'b001);
    req_valid = 3'b000;
    #1;
    check_eq("idle_ready", req_ready, 3'b000);
    tick();
    check_eq("idle_we3", WE3, 1'b0);

    // Single requester 1.
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    check_eq("single_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    check_eq("single_we3", WE3, 1'b1);
    check_eq("single_a3", A3, 5'd7);
    check_eq("single_wd3", WD3, 32'hDEAD_BEEF);
    check_eq("single_cnt", commit_cnt, 4'd1);
    tick();
    check_eq("single_we3_drop", WE3, 1'b0);
    check_eq("single_a3_hold", A3, 5'd7);

    // Reset back to pointer 0 / count 0, then all three valid for six cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, 5'd2, 32'h1000_0001);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("rr_ready_%0d", c), req_ready, 3'b001 << (c % 3));
      tick();
      check_eq($sformatf("rr_we3_%0d", c), WE3, 1'b1);
      check_eq($sformatf("rr_a3_%0d", c), A3, 5'(c % 3 + 1));
      check_eq($sformatf("rr_wd3_%0d", c), WD3, 32'h1000_0000 + 32'(c % 3));
    end
    req_valid = 3'b000;
    check_eq("rr_cnt", commit_cnt, 4'd6);
    tick();
    check_eq("rr_we3_after", WE3, 1'b0);

    // Write to x0: handshake, no enable, no count, pointer advances.
    set_req(0, 5'd0, 32'h0000_1234);
    req_valid = 3'b001;
    #1;
    check_eq("x0_ready", req_ready, 3'b001);
    tick();
    check_eq("x0_we3", WE3, 1'b0);
    check_eq("x0_a3", A3, 5'd0);
    check_eq("x0_wd3", WD3, 32'h0000_1234);
    check_eq("x0_cnt", commit_cnt, 4'd6);
    req_valid = 3'b111;
    #1;
    check_eq("x0_ptr_adv", req_ready, 3'b010);

    // In-flight write completes through a 3-cycle stall; req2 waits.
    set_req(1, 5'd5, 32'hCAFE_0005);
    req_valid = 3'b010;
    #1;
    check_eq("stall_pre_ready", req_ready, 3'b010);
    tick();
    wb_stall  = 1'b1;
    set_req(2, 5'd10, 32'hCAFE_000A);
    req_valid = 3'b100;
    #1;
    check_eq("stall_inflight_we3", WE3, 1'b1);
    check_eq("stall_inflight_a3", A3, 5'd5);
    check_eq("stall_ready_0", req_ready, 3'b000);
    for (int c = 1; c < 3; c++) begin
      tick();
      check_eq($sformatf("stall_we3_%0d", c), WE3, 1'b0);
      check_eq($sformatf("stall_ready_%0d", c), req_ready, 3'b000);
    end
    tick();
    wb_stall = 1'b0;
    #1;
    check_eq("unstall_ready", req_ready, 3'b100);
    tick();
    req_valid = 3'b000;
    check_eq("unstall_we3", WE3, 1'b1);
    check_eq("unstall_a3", A3, 5'd10);
    check_eq("unstall_cnt", commit_cnt, 4'd8);

    // Eight more commits wrap the 4-bit counter from 15 to 0.
    set_req(0, 5'd1, 32'h1000_0000);
    set_req(1, 5'd2, 32'h1000_0001);
    set_req(2, 5'd3, 32'h1000_0002);
    req_valid = 3'b111;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 6) check_eq("wrap_cnt_15", commit_cnt, 4'd15);
    end
    req_valid = 3'b000;
    check_eq("wrap_cnt_0", commit_cnt, 4'd0);
    tick();

    // Write to x9 in flight, then reset drops it.
    set_req(0, 5'd9, 32'hA5A5_A5A5);
    req_valid = 3'b001;
    #1;
    check_eq("mid_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check_eq("mid_we3", WE3, 1'b1);
`ifdef REGFILE_WB_FWD_EN
    rd_a1  = 5'd9;
    rf_rd1 = 32'd0;
    rd_a2  = 5'd0;
    rf_rd2 = 32'h1111_2222;
    #1;
    check_eq("fwd_rd1_hit", fwd_rd1, 32'hA5A5_A5A5);
    check_eq("fwd_rd2_x0", fwd_rd2, 32'h1111_2222);
`endif
    rst       = 1'b1;
    req_valid = 3'b111;
    #1;
    check_eq("mid_rst_ready", req_ready, 3'b000);
    tick();
    rst       = 1'b0;
    req_valid = 3'b000;
    check_eq("mid_rst_we3", WE3, 1'b0);
    check_eq("mid_rst_cnt", commit_cnt, 4'd0);
    check_eq("mid_rst_a3", A3, 5'd0);
`ifdef REGFILE_WB_FWD_EN
    rf_rd1 = 32'h0000_7777;
    #1;
    check_eq("fwd_rd1_miss", fwd_rd1, 32'h0000_7777);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
